// File: rtl/serial_sub_seq.sv
// Bit-serial subtractor: diff = a - b - bin over W cycles through one full_sub cell.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_sub_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(W - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e        state_q;
    logic [W-1:0]  a_sr_q;
    logic [W-1:0]  b_sr_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt_q;
    logic          brw_q;

    logic          cell_di;
    logic          cell_bor;
    logic [W-1:0]  res_next;

    full_sub u_full_sub (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .c   (brw_q),
        .di  (cell_di),
        .bor (cell_bor)
    );

    // New bit enters at the MSB so the first (LSB) bit ends up at bit 0 after W shifts.
    assign res_next = (res_q >> 1) | (W'(cell_di) << (W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    res_q  <= res_next;
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    brw_q  <= cell_bor;
                    if (cnt_q == LastCnt) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bout    <= cell_bor;
`ifdef SERIAL_SUB_SAT_EN
                        diff    <= cell_bor ? '0 : res_next;
`else
                        diff    <= res_next;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// One-bit full subtractor: di = a - b - c, bor set when a < b + c.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic di,
    output logic bor
);
    assign di  = a ^ b ^ c;
    assign bor = (~a & b) | (~(a ^ b) & c);
endmodule

// File: tb/tb_serial_sub_seq.sv
// Scoreboard bench for serial_sub_seq: driver pushes expected results, monitor checks on done.
module tb_serial_sub_seq;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   busy_start = 0;
    int   busy_end = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    serial_sub_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int ua, input int ub, input int ubin, input int c);
        exp_t e;
        int   r;
        r      = ua - ub - ubin;
        e.bout = (ua < ub + ubin);
        e.diff = W'((r + (1 << W)) % (1 << W));
`ifdef SERIAL_SUB_SAT_EN
        if (e.bout) e.diff = '0;
`endif
        e.cyc  = c;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("busy_window", int'(busy), int'(cyc >= busy_start && cyc < busy_end));
            if (busy && done) check("busy_done_excl", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", int'(diff), int'(e.diff));
                    check("bout", int'(bout), int'(e.bout));
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called at a falling edge with the DUT idle; returns one falling edge after acceptance.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tbin);
        a          = ta;
        b          = tb2;
        bin        = tbin;
        start      = 1'b1;
        busy_start = cyc + 1;
        busy_end   = cyc + 1 + int'(W);
        exp_q.push_back(model(int'(ta), int'(tb2), int'(tbin), cyc + 1 + int'(W)));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h05, 8'h03, 1'b0); drain();
        issue(8'h03, 8'h05, 1'b0); drain();
        issue(8'h00, 8'h00, 1'b1); drain();
        issue(8'hFF, 8'h00, 1'b1); drain();

        // start pulsed mid-run with different operands must be ignored
        issue(8'h80, 8'h01, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // asynchronous reset mid-operation
        issue(8'h55, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_bout", int'(bout), 0);
        exp_q.delete();
        busy_start = 0;
        busy_end   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'h10, 8'h01, 1'b0); drain();

        // back-to-back: second start presented in the done cycle
        issue(8'h21, 8'h07, 1'b0);
        while (cyc < busy_end) @(negedge clk);
        issue(8'h0A, 8'h0A, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                while (cyc < busy_end) @(negedge clk);
            end else begin
                drain();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected end", cyc);
        $fatal(1);
    end
endmodule
